debug_console_rx: RTL
=====================

// Module: debug_console_rx
// PURPOSE
//   Memory-mapped debug console input for one tile: the read-side counterpart of the tile's debug console output.
//   Buffers a host/testbench byte stream (valid/ready) in a FIFO; the tile CPU pops characters via bus reads.
//   Provides status and control registers and a level interrupt.
//   Sits on the tile peripheral bus beside the console-output sink; shares its bus signal set plus a read-data return.
// PARAMETERS
//   ADDRESS  16'h0000  tile address {x[15:8], y[7:0]}; identification only, no decode effect
//   DEPTH    16        FIFO entries; power of two, >= 2
// PORTS
//   clk_i       in   1   clock; all logic on posedge
//   rst_i       in   1   synchronous reset, active-high
//   rx_valid_i  in   1   host byte valid
//   rx_data_i   in   8   host byte
//   rx_ready_o  out  1   FIFO can accept the byte
//   en_i        in   1   bus access strobe
//   we_i        in   1   1 = write, 0 = read
//   addr_i      in   24  register byte offset
//   data_i      in   32  write data
//   data_o      out  32  read data, registered
//   irq_o       out  1   level interrupt: data available and enabled
// BEHAVIOUR
//   Reset (rst_i=1 at posedge): FIFO empty, rd/wr pointers 0, count 0, irq_en 0, data_o 0.
//     rx_ready_o = 0 and irq_o = 0 while rst_i is high.
//   Push
//     rx_ready_o = !rst_i && (count != DEPTH); not pop-aware.
//     A byte is stored when rx_valid_i && rx_ready_o at posedge. No overflow is possible.
//   Register map (addr_i, exact match; all other offsets read 0, writes ignored)
//     24'h000000 DATA (RO, pop)
//       Non-empty: read returns {23'b0, 1'b1, head byte} and pops the head.
//       Empty: read returns 32'h0 and pops nothing.
//     24'h000004 STATUS (RO)
//       Returns {16'b0, count[7:0], 5'b0, irq_en, full, empty}.
//       Count is zero-extended to 8 bits.
//     24'h000008 CTRL
//       Write bit0 -> irq_en.
//       Write bit1 = 1 -> flush: pointers and count to 0 at that edge. bit1 is self-clearing.
//       Read returns {31'b0, irq_en}.
//   Read latency
//     data_o updates at the posedge where en_i && !we_i; the value is visible the following cycle.
//     data_o holds its value otherwise, including on writes.
//     Back-to-back DATA reads pop consecutive bytes, one per cycle.
//   Simultaneous push and pop
//     count unchanged; both pointers advance.
//     A pop on a one-entry FIFO with a concurrent push returns the old head; the new byte remains.
//   Flush concurrent with a push: flush wins; the handshaked byte is discarded.
//   Pointers: log2(DEPTH) bits, wrap naturally. count: log2(DEPTH)+1 bits.
//     full = (count == DEPTH); empty = (count == 0).
//   irq_o = irq_en && !empty, from registered state; no glitch on the bus strobe.
//   Reset mid-stream (rst_i during a push or read) discards FIFO contents; the byte is not stored.
// TESTING
//   1. Reset, then push 'H','i' -> DATA reads return 0x148, 0x169, then 0x000; STATUS=0x00000001 afterwards.
//   2. Push 16 bytes with no reads -> rx_ready_o=0, STATUS=0x00001002. One DATA read pops the
//      first byte; rx_ready_o=1 on the next cycle.
//   3. Write CTRL=1 with FIFO empty -> irq_o=0. Push 0x41 -> irq_o=1 one cycle after the handshake.
//      Read DATA -> irq_o=0.
//   4. One byte queued; same cycle: push 0x42 and DATA read -> returns the old head. count stays 1.
//      Next read returns 0x142.
//   5. Five bytes queued; write CTRL=0x3 together with a push -> STATUS=0x00000005 (irq_en=1, empty).
//      The pushed byte is lost.
//   6. Assert rst_i for 1 cycle with 3 bytes queued -> empty, data_o=0, irq_en=0. Reads of 0x00C return 0.

Source files
------------

// File: rtl/debug_console_rx.sv
// Debug console input: buffers a host byte stream in a FIFO that the tile CPU
// drains through memory-mapped DATA/STATUS/CTRL registers, with a level interrupt.
module debug_console_rx #(
  parameter logic [15:0] ADDRESS = 16'h0000,
  parameter int          DEPTH   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  input  logic        en_i,
  input  logic        we_i,
  input  logic [23:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [23:0] REG_DATA   = 24'h000000;
  localparam logic [23:0] REG_STATUS = 24'h000004;
  localparam logic [23:0] REG_CTRL   = 24'h000008;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          irq_en_q, irq_en_d;
  logic [31:0]   data_q, data_d;

  logic empty, full, push, pop, bus_rd, bus_wr, ctrl_wr, flush;

  // ADDRESS is identification only; upper write-data bits have no register behind them.
  logic unused_ok;
  assign unused_ok = ^{data_i[31:2], ADDRESS};

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_CNT);
  assign rx_ready_o = !rst_i && !full;
  assign irq_o      = !rst_i && irq_en_q && !empty;

  assign push    = rx_valid_i && rx_ready_o;
  assign bus_rd  = en_i && !we_i;
  assign bus_wr  = en_i && we_i;
  assign ctrl_wr = bus_wr && (addr_i == REG_CTRL);
  assign flush   = ctrl_wr && data_i[1];
  assign pop     = bus_rd && (addr_i == REG_DATA) && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    irq_en_d = irq_en_q;
    data_d   = data_q;

    if (ctrl_wr) irq_en_d = data_i[0];

    // Flush overrides any concurrent push or pop.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    if (bus_rd) begin
      case (addr_i)
        REG_DATA:   data_d = empty ? 32'h0 : {23'b0, 1'b1, mem_q[rd_ptr_q]};
        REG_STATUS: data_d = {16'b0, 8'(count_q), 5'b0, irq_en_q, full, empty};
        REG_CTRL:   data_d = {31'b0, irq_en_q};
        default:    data_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      irq_en_q <= 1'b0;
      data_q   <= 32'h0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      irq_en_q <= irq_en_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push && !flush) mem_q[wr_ptr_q] <= rx_data_i;
  end

  assign data_o = data_q;

endmodule
